// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B3 classic initiator: valid/ready command in, one bus cycle, response out.
// Optional WBM_ERR_EN adds a wbm_err_i input that terminates a cycle with an error response.
module wb_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADR_W          = 32,
   parameter int unsigned DAT_W          = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n_i,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_we,
   input  logic [ADR_W-1:0]   cmd_adr,
   input  logic [DAT_W-1:0]   cmd_dat,
   input  logic [DAT_W/8-1:0] cmd_sel,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DAT_W-1:0]   rsp_dat,
   output logic               rsp_err,
   output logic               busy,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [DAT_W/8-1:0] wbm_sel_o,
   output logic [ADR_W-1:0]   wbm_adr_o,
   output logic [DAT_W-1:0]   wbm_dat_o,
   input  logic [DAT_W-1:0]   wbm_dat_i,
`ifdef WBM_ERR_EN
   input  logic               wbm_err_i,
`endif
   input  logic               wbm_ack_i
);

   localparam bit          ToEn   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] ToLast = ToEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e      state_q;
   logic [15:0] cnt_q;
   logic        bus_err;

`ifdef WBM_ERR_EN
   assign bus_err = wbm_err_i;
`else
   assign bus_err = 1'b0;
`endif

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StBus;
               end
            end
            StBus: begin
               // Priority: bus error, then ack, then timeout.
               if (bus_err) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else if (ToEn && (cnt_q == ToLast)) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized self-checking bench for wb_initiator (TIMEOUT_CYCLES=8); WBM_ERR_EN exercises the err path.
module tb_wb_initiator;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] rd_val = '0;
   int          ws_target = 255;
   int          ws_cnt;
   logic        stray_ack = 1'b0;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   // Slave: acks after ws_target wait states (255 = never), plus optional stray ack.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ws_cnt <= 0;
      else        ws_cnt <= wbm_stb_o ? ws_cnt + 1 : 0;
   end
   assign wbm_ack_i = (wbm_stb_o && (ws_cnt == ws_target)) || stray_ack;

`ifdef WBM_ERR_EN
   logic err_en = 1'b0;
   logic wbm_err_i;
   assign wbm_err_i = wbm_stb_o && err_en && (ws_cnt == ws_target);
`endif

   wb_initiator #(.TIMEOUT_CYCLES(T), .ADR_W(32), .DAT_W(32)) dut (
      .wb_clk_i  (clk),
      .wb_rst_n_i(rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (rd_val),
`ifdef WBM_ERR_EN
      .wbm_err_i (wbm_err_i),
`endif
      .wbm_ack_i (wbm_ack_i)
   );

   // One command through the DUT; expectations come from the transaction-level rules:
   // err ends after w+1 cycles, ack ends after w+1 cycles if that is within T, else timeout at T.
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int w, input logic err_inj,
                         input int hold, input logic [31:0] rd);
      int          exp_cycles, cycles;
      logic        exp_err;
      logic [31:0] exp_dat;
      if (err_inj && w < T) begin
         exp_err = 1'b1; exp_cycles = w + 1;
      end else if (w < T) begin
         exp_err = 1'b0; exp_cycles = w + 1;
      end else begin
         exp_err = 1'b1; exp_cycles = T;
      end
      exp_dat = (!exp_err && !we) ? rd : 32'h0;

      @(negedge clk);
      ws_target = w; rd_val = rd;
`ifdef WBM_ERR_EN
      err_en = err_inj;
`endif
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cycles = 0;
      while (wbm_cyc_o === 1'b1 && cycles < 100) begin
         cycles++;
         n_vec++;
         if ({wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_valid, cmd_ready, busy}
             !== {1'b1, we, adr, dat, sel, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL bus_hold got stb=%b we=%b adr=%h dat=%h sel=%h rv=%b rdy=%b busy=%b want we=%b adr=%h dat=%h sel=%h",
                     wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_valid, cmd_ready,
                     busy, we, adr, dat, sel);
         end
         @(negedge clk);
      end
      n_vec++;
      if (cycles != exp_cycles) begin
         n_err++; $display("FAIL cyc_cycles got %0d want %0d", cycles, exp_cycles);
      end
      n_vec++;
      if ({rsp_valid, rsp_err, rsp_dat, wbm_stb_o} !== {1'b1, exp_err, exp_dat, 1'b0}) begin
         n_err++;
         $display("FAIL response got v=%b err=%b dat=%h want v=1 err=%b dat=%h",
                  rsp_valid, rsp_err, rsp_dat, exp_err, exp_dat);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_vec++;
         if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o} !== {1'b1, exp_err, exp_dat, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rsp_hold got v=%b err=%b dat=%h rdy=%b cyc=%b want v=1 err=%b dat=%h rdy=0 cyc=0",
                     rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o, exp_err, exp_dat);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_vec++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
         n_err++;
         $display("FAIL rsp_done got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                  rsp_valid, cmd_ready, busy);
      end
   endtask

   task automatic test_reset();
      #3;
      n_vec++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_err}
          !== '0) begin
         n_err++;
         $display("FAIL reset_state got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b rd=%h re=%b want all 0",
                  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid,
                  rsp_dat, rsp_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_err++; $display("FAIL post_reset got rdy=%b busy=%b want rdy=1 busy=0", cmd_ready, busy);
      end
   endtask

   task automatic test_write_wait();
      do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, 0, 32'hAAAA_5555);
   endtask

   task automatic test_read_zero_wait();
      do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 1'b0, 0, 32'h1234_5678);
   endtask

   task automatic test_timeout();
      do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 255, 1'b0, 1, 32'h5A5A_5A5A);
      do_txn(1'b1, 32'h3000_0014, 32'hCAFE_F00D, 4'h3, T - 1, 1'b0, 0, 32'h0);
      do_txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, T - 1, 1'b0, 0, 32'h0BAD_CAFE);
   endtask

   task automatic test_backpressure();
      do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 1'b0, 5, 32'h8765_4321);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ws_target = 255;
      cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({wbm_cyc_o, wbm_stb_o, rsp_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL async_reset got cyc=%b stb=%b rv=%b want 0", wbm_cyc_o, wbm_stb_o, rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({rsp_valid, wbm_cyc_o, cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL stray_ack got rv=%b cyc=%b rdy=%b want rv=0 cyc=0 rdy=1",
                     rsp_valid, wbm_cyc_o, cmd_ready);
         end
      end
      stray_ack = 1'b0;
   endtask

   task automatic test_err();
`ifdef WBM_ERR_EN
      do_txn(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF, 1, 1'b1, 0, 32'h0);
      do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 0, 1'b1, 1, 32'hFFFF_0000);
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int w;
         w = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, T - 1));
         do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), w, 1'b0,
                int'($urandom_range(0, 3)), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_write_wait();
      test_read_zero_wait();
      test_timeout();
      test_backpressure();
      test_async_reset();
      test_err();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
